// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 round-robin / fixed-select mux.
// Imported by mux_n1_rr and rr_pick.
package mux_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  // Ceiling log2, floored at 1 so index fields never collapse to zero width.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr.
// Ports: i_req (requests), i_ptr (start index), o_found, o_idx (winner).
module rr_pick
  import mux_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic          o_found,
  output logic [PW-1:0] o_idx
);

  localparam logic [PW:0] NL = (PW+1)'(N);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;
  logic [PW-1:0]  w_off;
  logic [PW:0]    w_sum;

  // Rotate so that bit 0 of w_rot is request i_ptr.
  assign w_dbl = {i_req, i_req} >> i_ptr;
  assign w_rot = w_dbl[N-1:0];

  // Priority encode: scanning downward leaves the lowest set bit.
  always_comb begin
    o_found = 1'b0;
    w_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        o_found = 1'b1;
        w_off   = PW'(k);
      end
    end
  end

  // Un-rotate: (ptr + offset) mod N.
  assign w_sum = {1'b0, i_ptr} + {1'b0, w_off};
  assign o_idx = (w_sum >= NL) ? PW'(w_sum - NL) : w_sum[PW-1:0];

endmodule

// File: rtl/mux_n1_rr.sv
// N:1 mux with registered output, per-channel valid/ready, fixed or RR select.
// Ports: clk_in, rst_in, mode_in, sel_in, data_in, valid_in, ready_out,
//        y_out, y_valid_out, y_ready_in, grant_out.
module mux_n1_rr
  import mux_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = clog2(N)
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             mode_in,
  input  logic [SEL_W-1:0] sel_in,
  input  logic [N*W-1:0]   data_in,
  input  logic [N-1:0]     valid_in,
  output logic [N-1:0]     ready_out,
  output logic [W-1:0]     y_out,
  output logic             y_valid_out,
  input  logic             y_ready_in,
  output logic [SEL_W-1:0] grant_out
);

  localparam logic [SEL_W:0] NL = (SEL_W+1)'(N);

  logic [W-1:0]     r_y;
  logic             r_valid;
  logic [SEL_W-1:0] r_grant;
  logic [SEL_W-1:0] r_ptr;

  logic             w_free;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic             w_fx_found;
  logic             w_found;
  logic [SEL_W-1:0] w_cand;
  logic             w_xfer;
  logic [SEL_W:0]   w_inc;
  logic [SEL_W-1:0] w_ptr_nxt;

  rr_pick #(
    .N  (N),
    .PW (SEL_W)
  ) u_pick (
    .i_req   (valid_in),
    .i_ptr   (r_ptr),
    .o_found (w_rr_found),
    .o_idx   (w_rr_idx)
  );

  assign w_free = !r_valid || y_ready_in;

  // Out-of-range select never grants.
  assign w_fx_found = ({1'b0, sel_in} < NL) && valid_in[sel_in];

  assign w_found = (mode_in == MODE_RR) ? w_rr_found : w_fx_found;
  assign w_cand  = (mode_in == MODE_RR) ? w_rr_idx : sel_in;

  // A granted channel is always valid, so ready alone implies transfer.
  assign w_xfer = w_free && w_found && !rst_in;

  always_comb begin
    ready_out = '0;
    for (int k = 0; k < N; k++) begin
      ready_out[k] = w_xfer && (w_cand == SEL_W'(k));
    end
  end

  assign w_inc     = {1'b0, w_cand} + 1'b1;
  assign w_ptr_nxt = (w_inc >= NL) ? '0 : w_inc[SEL_W-1:0];

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_y     <= '0;
      r_valid <= 1'b0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (w_xfer) begin
      r_y     <= data_in[w_cand*W +: W];
      r_valid <= 1'b1;
      r_grant <= w_cand;
      if (mode_in == MODE_RR) begin
        r_ptr <= w_ptr_nxt;
      end
    end else if (r_valid && y_ready_in) begin
      r_valid <= 1'b0;
    end
  end

  assign y_out       = r_y;
  assign y_valid_out = r_valid;
  assign grant_out   = r_grant;

endmodule

// File: tb/tb_mux_n1_rr.sv
// Directed self-checking bench for mux_n1_rr (N=4, W=8).
// Expected values are hand-computed per vector.
module tb_mux_n1_rr;

  logic        clk;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [31:0] data;
  logic [3:0]  vin;
  logic [3:0]  rdy;
  logic [7:0]  y;
  logic        yv;
  logic        yr;
  logic [1:0]  gnt;

  int n_chk;
  int n_err;

  mux_n1_rr #(
    .N (4),
    .W (8)
  ) dut (
    .clk_in      (clk),
    .rst_in      (rst),
    .mode_in     (mode),
    .sel_in      (sel),
    .data_in     (data),
    .valid_in    (vin),
    .ready_out   (rdy),
    .y_out       (y),
    .y_valid_out (yv),
    .y_ready_in  (yr),
    .grant_out   (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [7:0] ey,
                         input logic ev, input logic [1:0] eg);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".v"}, 32'(yv), 32'(ev));
    chk({tag, ".g"}, 32'(gnt), 32'(eg));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst   = 1'b1;
    mode  = 1'b0;
    sel   = 2'd0;
    data  = {8'h13, 8'h12, 8'h11, 8'h10};
    vin   = 4'b1111;
    yr    = 1'b1;
    step();
    step();
    chk("rst.rdy", 32'(rdy), 32'h0);
    chk_out("rst", 8'h00, 1'b0, 2'd0);

    // Fixed mode, channel 2.
    rst  = 1'b0;
    sel  = 2'd2;
    data = {8'h13, 8'hA5, 8'h11, 8'h10};
    vin  = 4'b0100;
    #1;
    chk("fx.rdy", 32'(rdy), 32'h4);
    step();
    chk_out("fx", 8'hA5, 1'b1, 2'd2);

    // Selected channel not valid: no grant, output drains.
    vin = 4'b1011;
    #1;
    chk("fx_none.rdy", 32'(rdy), 32'h0);
    step();
    chk_out("fx_none", 8'hA5, 1'b0, 2'd2);

    // Round-robin, all valid, ptr starts at 0.
    mode = 1'b1;
    data = {8'h13, 8'h12, 8'h11, 8'h10};
    vin  = 4'b1111;
    #1;
    chk("rr.rdy0", 32'(rdy), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("rr", 8'h10 + 8'(i % 4), 1'b1, 2'(i % 4));
    end
    // ptr now 1; force ch3 to land ptr at 0.
    vin = 4'b1000;
    #1;
    chk("rr.rdy3", 32'(rdy), 32'h8);
    step();
    chk_out("rr3", 8'h13, 1'b1, 2'd3);

    // Backpressure with valid 1010 from ptr 0.
    vin = 4'b1010;
    #1;
    chk("bp.rdy1", 32'(rdy), 32'h2);
    step();
    chk_out("bp1", 8'h11, 1'b1, 2'd1);
    yr = 1'b0;
    #1;
    chk("bp.stall_rdy", 32'(rdy), 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp.hold_rdy", 32'(rdy), 32'h0);
      chk_out("bp.hold", 8'h11, 1'b1, 2'd1);
    end
    yr = 1'b1;
    #1;
    chk("bp.rel_rdy", 32'(rdy), 32'h8);
    step();
    chk_out("bp3", 8'h13, 1'b1, 2'd3);
    chk("bp.rdy1b", 32'(rdy), 32'h2);
    step();
    chk_out("bp1b", 8'h11, 1'b1, 2'd1);

    // Reset mid-stream: valid held, ptr=2.
    vin = 4'b1111;
    rst = 1'b1;
    #1;
    chk("mrst.rdy", 32'(rdy), 32'h0);
    step();
    chk_out("mrst", 8'h00, 1'b0, 2'd0);
    rst = 1'b0;
    #1;
    chk("mrst.rdy0", 32'(rdy), 32'h1);
    step();
    chk_out("mrst0", 8'h10, 1'b1, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
